// File: rtl/secded_decoder_if.sv
// Valid/ready codeword channel into the SEC-DED decoder and result channel out of it.
// The decoder takes the slave view and the producer/consumer side takes the master view.
interface secded_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_parity;
    logic        in_parity_DED;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_corrected;
    logic        out_uncorrectable;
    logic [5:0]  out_syndrome;

    modport slave (
        input  in_valid, in_data, in_parity, in_parity_DED, out_ready,
        output in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
    );

    modport master (
        output in_valid, in_data, in_parity, in_parity_DED, out_ready,
        input  in_ready, out_valid, out_data, out_corrected, out_uncorrectable, out_syndrome
    );
endinterface

// File: rtl/secded_decoder.sv
// Two-stage pipelined 32-bit SEC-DED (39,32) decoder with saturating error counters.
// Optional macro SECDED_ERR_LOG_EN adds a sticky first-uncorrectable-error syndrome log.
module secded_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    secded_decoder_if.slave  bus,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`ifdef SECDED_ERR_LOG_EN
    ,
    output logic             log_valid,
    output logic [5:0]       log_syndrome
`endif
);

    // Hamming position of data bit idx: the idx-th non-power-of-two position in 1..38.
    function automatic logic [5:0] data_pos(input int idx);
        int n;
        n = 0;
        data_pos = '0;
        for (int q = 1; q <= 38; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == idx) data_pos = q[5:0];
                n++;
            end
        end
    endfunction

    function automatic logic [31:0] parity_mask(input int k);
        logic [5:0] p;
        parity_mask = '0;
        for (int i = 0; i < 32; i++) begin
            p = data_pos(i);
            parity_mask[i] = p[k];
        end
    endfunction

    logic [5:0]  calc_parity;
    logic [31:0] flip_mask;
    logic        overall;

    logic        s1_valid_reg;
    logic [31:0] s1_data_reg;
    logic [5:0]  s1_syndrome_reg;
    logic        s1_overall_reg;

    logic        out_valid_reg;
    logic [31:0] out_data_reg;
    logic        out_corr_reg;
    logic        out_uncorr_reg;
    logic [5:0]  out_syndrome_reg;

    logic [CNT_W-1:0] corr_cnt_reg;
    logic [CNT_W-1:0] uncorr_cnt_reg;

    logic        s2_ready;
    logic        in_ready_int;
    logic        out_fire;
    logic        syn_pow2;
    logic [31:0] cls_data_next;
    logic        cls_corr_next;
    logic        cls_uncorr_next;

    for (genvar gi = 0; gi < 6; gi++) begin : g_parity
        localparam logic [31:0] MASK = parity_mask(gi);
        assign calc_parity[gi] = ^(bus.in_data & MASK);
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_flip
        localparam logic [5:0] POS = data_pos(gi);
        assign flip_mask[gi] = (s1_syndrome_reg == POS);
    end

    assign overall = (^bus.in_data) ^ (^bus.in_parity) ^ bus.in_parity_DED;

    // The output slot is free when empty or being drained; stage 1 inherits that.
    assign s2_ready     = !out_valid_reg || bus.out_ready;
    assign in_ready_int = !s1_valid_reg || s2_ready;
    assign out_fire     = out_valid_reg && bus.out_ready;

    assign syn_pow2 = (s1_syndrome_reg != 6'd0) &&
                      ((s1_syndrome_reg & (s1_syndrome_reg - 6'd1)) == 6'd0);

    always_comb begin
        cls_data_next   = s1_data_reg;
        cls_corr_next   = 1'b0;
        cls_uncorr_next = 1'b0;
        if (s1_overall_reg) begin
            if (s1_syndrome_reg == 6'd0 || syn_pow2) begin
                cls_corr_next = 1'b1;
            end else if (|flip_mask) begin
                cls_corr_next = 1'b1;
                cls_data_next = s1_data_reg ^ flip_mask;
            end else begin
                cls_uncorr_next = 1'b1;
            end
        end else if (s1_syndrome_reg != 6'd0) begin
            cls_uncorr_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_data_reg     <= '0;
            s1_syndrome_reg <= '0;
            s1_overall_reg  <= 1'b0;
        end else if (in_ready_int) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_reg     <= bus.in_data;
                s1_syndrome_reg <= calc_parity ^ bus.in_parity;
                s1_overall_reg  <= overall;
            end
        end
    end

    // Payload only changes when a new word moves in, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_corr_reg     <= 1'b0;
            out_uncorr_reg   <= 1'b0;
            out_syndrome_reg <= '0;
        end else if (s2_ready) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg     <= cls_data_next;
                out_corr_reg     <= cls_corr_next;
                out_uncorr_reg   <= cls_uncorr_next;
                out_syndrome_reg <= s1_syndrome_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            corr_cnt_reg   <= '0;
            uncorr_cnt_reg <= '0;
        end else if (out_fire) begin
            if (out_corr_reg && corr_cnt_reg != '1)
                corr_cnt_reg <= corr_cnt_reg + 1'b1;
            if (out_uncorr_reg && uncorr_cnt_reg != '1)
                uncorr_cnt_reg <= uncorr_cnt_reg + 1'b1;
        end
    end

`ifdef SECDED_ERR_LOG_EN
    logic       log_valid_reg;
    logic [5:0] log_syndrome_reg;

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            log_valid_reg    <= 1'b0;
            log_syndrome_reg <= '0;
        end else if (out_fire && out_uncorr_reg && !log_valid_reg) begin
            log_valid_reg    <= 1'b1;
            log_syndrome_reg <= out_syndrome_reg;
        end
    end

    assign log_valid    = log_valid_reg;
    assign log_syndrome = log_syndrome_reg;
`endif

    assign bus.in_ready          = in_ready_int;
    assign bus.out_valid         = out_valid_reg;
    assign bus.out_data          = out_data_reg;
    assign bus.out_corrected     = out_corr_reg;
    assign bus.out_uncorrectable = out_uncorr_reg;
    assign bus.out_syndrome      = out_syndrome_reg;
    assign corr_cnt              = corr_cnt_reg;
    assign uncorr_cnt            = uncorr_cnt_reg;

endmodule
